// File: rtl/corr_flag_sequencer_pkg.sv
// Shared types and default sizing for the correlation flag-strobe receiver.
// The state encoding is fixed so that other blocks and debug tools can decode it.
package corr_flag_sequencer_pkg;

    localparam int W_DEF      = 16;
    localparam int CW_DEF     = 8;
    localparam int MAXWIN_DEF = 200;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        ACTIVE = 2'd2,
        REPORT = 2'd3
    } state_t;

endpackage

// File: rtl/corr_flag_sequencer_if.sv
// Strobe and report bundle between the flag-strobe generator (master) and the
// sequencer (slave).
interface corr_flag_sequencer_if
    import corr_flag_sequencer_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int CW = CW_DEF
);
    logic          LoadCorr;
    logic          SetFlag;
    logic          ClrFlag;
    logic          Sample;
    logic [W-1:0]  CorrIn;
    logic          OutReady;
    logic          Flag;
    logic          OutValid;
    logic [W-1:0]  OutCorr;
    logic [CW-1:0] OutLen;
    logic          OutTimeout;
    logic          SeqErr;
    logic          Dropped;

    modport master (
        output LoadCorr, SetFlag, ClrFlag, Sample, CorrIn, OutReady,
        input  Flag, OutValid, OutCorr, OutLen, OutTimeout, SeqErr, Dropped
    );

    modport slave (
        input  LoadCorr, SetFlag, ClrFlag, Sample, CorrIn, OutReady,
        output Flag, OutValid, OutCorr, OutLen, OutTimeout, SeqErr, Dropped
    );
endinterface

// File: rtl/corr_flag_sequencer_win_counter.sv
// Window-length counter: clears on window open, counts enabled samples and
// flags the sample that brings the count to MAXWIN. It holds at MAXWIN.
module win_counter
    import corr_flag_sequencer_pkg::*;
#(
    parameter int CW     = CW_DEF,
    parameter int MAXWIN = MAXWIN_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clr,
    input  logic          i_en,
    output logic [CW-1:0] o_count,
    output logic          o_hit
);
    localparam logic [CW-1:0] MAXV = CW'(MAXWIN);

    logic [CW-1:0] r_count;
    logic [CW-1:0] w_inc;

    assign w_inc = r_count + CW'(1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != MAXV)) begin
            r_count <= w_inc;
        end
    end

    assign o_count = r_count;
    assign o_hit   = i_en && (w_inc == MAXV);

endmodule

// File: rtl/corr_flag_sequencer.sv
// Correlation flag-strobe receiver: captures the correlation value, tracks the
// flag window in Sample strobes and hands one report record downstream per window.
module corr_flag_sequencer
    import corr_flag_sequencer_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int CW     = CW_DEF,
    parameter int MAXWIN = MAXWIN_DEF
) (
    input  logic                  Clk,
    input  logic                  Reset,
    corr_flag_sequencer_if.slave  bus
);
    state_t        r_state;
    state_t        w_next_state;
    logic [W-1:0]  r_corr;
    logic [CW-1:0] r_len;
    logic          r_timeout;
    logic          r_seq_err;
    logic          r_dropped;

    logic [CW-1:0] w_count;
    logic          w_hit;
    logic          w_cnt_en;
    logic          w_cnt_clr;
    logic          w_capture;
    logic          w_close;
    logic          w_timeout;
    logic          w_seq_err;
    logic          w_drop;
    logic [CW-1:0] w_len;

    assign w_cnt_en  = (r_state == ACTIVE) && bus.Sample;
    assign w_cnt_clr = (r_state == ARMED) && bus.SetFlag;

    win_counter #(.CW(CW), .MAXWIN(MAXWIN)) u_win_counter (
        .i_clk   (Clk),
        .i_rst_n (Reset),
        .i_clr   (w_cnt_clr),
        .i_en    (w_cnt_en),
        .o_count (w_count),
        .o_hit   (w_hit)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (bus.LoadCorr) w_next_state = ARMED;
            ARMED: begin
                if (bus.SetFlag)      w_next_state = ACTIVE;
                else if (bus.ClrFlag) w_next_state = IDLE;
            end
            ACTIVE:  if (bus.ClrFlag || w_hit) w_next_state = REPORT;
            REPORT:  if (bus.OutReady) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Closing length: a Sample coinciding with the close is counted; on a
    // timeout that same expression already equals MAXWIN.
    always_comb begin
        w_capture = 1'b0;
        w_close   = 1'b0;
        w_timeout = 1'b0;
        w_seq_err = 1'b0;
        w_drop    = 1'b0;
        w_len     = w_count + CW'(bus.Sample);
        case (r_state)
            IDLE: begin
                w_capture = bus.LoadCorr;
                w_seq_err = bus.SetFlag || bus.ClrFlag;
            end
            ARMED: begin
                w_capture = bus.LoadCorr && !bus.ClrFlag;
                w_seq_err = bus.ClrFlag;
            end
            ACTIVE: begin
                w_close   = bus.ClrFlag || w_hit;
                w_timeout = !bus.ClrFlag;
                w_seq_err = bus.SetFlag || bus.LoadCorr;
            end
            REPORT: begin
                w_drop    = bus.LoadCorr;
                w_seq_err = bus.SetFlag || bus.ClrFlag;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_corr    <= '0;
            r_len     <= '0;
            r_timeout <= 1'b0;
            r_seq_err <= 1'b0;
            r_dropped <= 1'b0;
        end else begin
            if (w_capture) r_corr <= bus.CorrIn;
            if (w_close) begin
                r_len     <= w_len;
                r_timeout <= w_timeout;
            end
            if (w_seq_err) r_seq_err <= 1'b1;
            if (w_drop)    r_dropped <= 1'b1;
        end
    end

    assign bus.Flag       = (r_state == ACTIVE);
    assign bus.OutValid   = (r_state == REPORT);
    assign bus.OutCorr    = r_corr;
    assign bus.OutLen     = r_len;
    assign bus.OutTimeout = r_timeout;
    assign bus.SeqErr     = r_seq_err;
    assign bus.Dropped    = r_dropped;

endmodule

// File: doc/corr_flag_sequencer.md
Name: corr_flag_sequencer

Overview:
- Receiving end of the correlation flag-strobe interface.
- Consumes three single-cycle strobes: LoadCorr (enable correlation register), SetFlag (activate flag) and ClrFlag (deactivate flag). In a legal sequence they arrive in the order LoadCorr, SetFlag, ClrFlag, with any gap between them.
- Holds the captured correlation value, drives the flag, and measures window length in Sample strobes.
- Emits one report record per window to downstream logic over a valid/ready handshake.

Parameters:
- W, 16, width of the correlation value.
- CW, 8, width of the window-length counter.
- MAXWIN, 200, window length (Sample strobes) that forces a timeout report. Must be ≤ 2^CW-1.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- LoadCorr  in  1  strobe: capture CorrIn.
- SetFlag  in  1  strobe: open window.
- ClrFlag  in  1  strobe: close window.
- Sample  in  1  sample-enable strobe, counted while the window is open.
- CorrIn  in  W  correlation value.
- OutReady  in  1  downstream accepts the record.
- Flag  out  1  window-open flag.
- OutValid  out  1  report record valid.
- OutCorr  out  W  captured correlation value.
- OutLen  out  CW  window length in Sample strobes.
- OutTimeout  out  1  record was closed by MAXWIN, not by ClrFlag.
- SeqErr  out  1  sticky: illegal strobe order seen.
- Dropped  out  1  sticky: window lost because a record was pending.

Behaviour:
- Reset asserted (Reset=0), asynchronously:
  - state=IDLE.
  - Flag, OutValid, OutTimeout, SeqErr and Dropped are 0.
  - OutCorr and OutLen are 0.
  - The internal counter is 0.
- All other updates occur on the rising edge of Clk.
- FSM states are IDLE, ARMED, ACTIVE and REPORT.
- IDLE:
  - LoadCorr: capture CorrIn into OutCorr and go to ARMED.
  - SetFlag or ClrFlag without LoadCorr: set SeqErr and stay in IDLE.
  - LoadCorr together with SetFlag in the same cycle: capture, then go to ARMED. SetFlag is ignored and SeqErr is set.
- ARMED:
  - SetFlag: Flag=1, counter=0, go to ACTIVE.
  - ClrFlag alone: set SeqErr and return to IDLE; the captured value is discarded.
  - LoadCorr again: recapture CorrIn and stay in ARMED. No error.
  - SetFlag and ClrFlag in the same cycle: SetFlag wins and SeqErr is set.
- ACTIVE:
  - Each Sample pulse increments the counter.
  - ClrFlag: Flag=0, OutLen=counter, OutTimeout=0, go to REPORT.
    - A Sample pulse in the same cycle as ClrFlag is counted.
  - Timeout: if the counter reaches MAXWIN on a Sample pulse and ClrFlag is absent, then Flag=0, OutLen=MAXWIN, OutTimeout=1, go to REPORT.
  - SetFlag or LoadCorr: set SeqErr. No other effect.
- REPORT:
  - OutValid=1. OutCorr, OutLen and OutTimeout are held stable until the handshake.
  - Handshake: OutValid&OutReady go to IDLE, with OutValid=0 the next cycle.
  - LoadCorr while in REPORT: set Dropped; the value is not captured. This applies even in the handshake cycle.
  - SetFlag or ClrFlag while in REPORT: set SeqErr.
- Latency:
  - ClrFlag at edge N gives OutValid=1 after edge N.
  - OutReady may be held high permanently, giving a 1-cycle REPORT.
- SeqErr and Dropped stay sticky until reset.
- Counter width rule: the counter cannot exceed MAXWIN, so it never wraps.
- Reset mid-window clears Flag immediately, without waiting for Clk.

Decomposition:
- Shared package:
  - State encoding constants (IDLE=2'd0, ARMED=2'd1, ACTIVE=2'd2, REPORT=2'd3).
  - W, CW and MAXWIN defaults, reused by the strobe generator and the correlator.
- Sub-module win_counter:
  - CW-bit counter with synchronous clear, enable and saturation compare to MAXWIN.
  - Outputs the count and a hit flag.
- The FSM and output registers stay in the top module.

Test Plan:
1. Normal flow: LoadCorr with CorrIn=16'h1A2B, SetFlag 2 cycles later, 7 Sample pulses, then ClrFlag, with OutReady=1 -> Flag high over the window; one-cycle OutValid with OutCorr=16'h1A2B, OutLen=7, OutTimeout=0.
2. Timeout: LoadCorr, then SetFlag, then 200 Sample pulses with no ClrFlag -> OutValid with OutLen=200 and OutTimeout=1; Flag drops on the edge of the 200th Sample.
3. Backpressure: OutReady=0 for 5 cycles after REPORT is entered, with LoadCorr pulsed during that time -> outputs stable for 5 cycles and Dropped=1. After OutReady=1, state is IDLE and no ARMED capture has occurred.
4. Order errors: SetFlag in IDLE -> SeqErr=1, Flag stays 0. Then a legal sequence still produces a correct record.
5. Simultaneous events: SetFlag and ClrFlag together in ARMED -> ACTIVE entered and SeqErr=1. ClrFlag together with Sample in ACTIVE after 3 prior Samples -> OutLen=4.
6. Async reset: Reset=0 mid-ACTIVE, between clock edges -> Flag, OutValid and the sticky flags go to 0 immediately. After release, LoadCorr is required before a window can open.
